// File: rtl/instr_pkg.sv
// Shared MIPS instruction-format constants for the field encoder and splitter.
package instr_pkg;

    localparam logic [1:0] FMT_R   = 2'd0;
    localparam logic [1:0] FMT_I   = 2'd1;
    localparam logic [1:0] FMT_J   = 2'd2;
    localparam logic [1:0] FMT_BAD = 2'd3;

    // MSB position of each field inside the 32-bit word
    localparam int OP_HI = 31;
    localparam int RS_HI = 25;
    localparam int RT_HI = 20;
    localparam int RD_HI = 15;
    localparam int SH_HI = 10;
    localparam int FN_HI = 5;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;

    function automatic logic is_shift_func(input logic [5:0] fn);
        return (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA);
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-tuple input handshake plus instruction-memory write port.
interface instr_encoder_if #(parameter int ADDR_W = 10) ();

    logic              in_valid;
    logic              in_ready;
    logic [1:0]        fmt;
    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        func;
    logic [15:0]       imm;
    logic [25:0]       index;
    logic              wr_en;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport slave (
        input  in_valid, fmt, opcode, rs, rt, rd, shamt, func, imm, index, wr_ready,
        output in_ready, wr_en, wr_addr, wr_data
    );

    modport master (
        output in_valid, fmt, opcode, rs, rt, rd, shamt, func, imm, index, wr_ready,
        input  in_ready, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/instr_encoder_sync_fifo.sv
// Single-clock FIFO; pushed data is at the head the cycle after the push edge.
// Push ignored when full, pop ignored when empty; head is a plain read of registered storage.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs MIPS R/I/J fields into 32-bit words, buffers them, writes them to imem at an
// auto-incrementing address; wr_en one cycle after accept, in_ready low only when full.
// ENC_FIELD_CHECK_EN adds opcode/format legality checks and a sticky err_field output.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    instr_encoder_if.slave         bus,
    input  logic                   addr_clr,
    output logic [$clog2(DEPTH):0] count,
`ifdef ENC_FIELD_CHECK_EN
    output logic                   err_field,
`endif
    output logic                   err_illegal
);

    logic [31:0]       enc;
    logic              illegal;
    logic              accept;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [ADDR_W-1:0] addr_q;

    always_comb begin
        enc = '0;
        case (bus.fmt)
            FMT_R: begin
                enc[OP_HI -: 6] = bus.opcode;
                enc[RS_HI -: 5] = bus.rs;
                enc[RT_HI -: 5] = bus.rt;
                enc[RD_HI -: 5] = bus.rd;
                enc[SH_HI -: 5] = bus.shamt;
                enc[FN_HI -: 6] = bus.func;
            end
            FMT_I: begin
                enc[OP_HI -: 6] = bus.opcode;
                enc[RS_HI -: 5] = bus.rs;
                enc[RT_HI -: 5] = bus.rt;
                enc[15:0]       = bus.imm;
            end
            default: begin
                enc[OP_HI -: 6] = bus.opcode;
                enc[25:0]       = bus.index;
            end
        endcase
    end

`ifdef ENC_FIELD_CHECK_EN
    assign illegal = (bus.fmt == FMT_BAD)
                  || ((bus.fmt == FMT_R) && (bus.opcode != 6'd0))
                  || ((bus.fmt != FMT_R) && (bus.opcode == 6'd0));
`else
    assign illegal = (bus.fmt == FMT_BAD);
`endif

    assign bus.in_ready = !full;
    assign accept       = bus.in_valid && bus.in_ready;
    assign push         = accept && !illegal;
    assign bus.wr_en    = !empty;
    assign pop          = bus.wr_en && bus.wr_ready;
    assign bus.wr_addr  = addr_q;

    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (enc),
        .pop       (pop),
        .pop_data  (bus.wr_data),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // Reload wins over increment; the popping write still uses the old address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= ADDR_W'(BASE_ADDR);
        end else if (addr_clr) begin
            addr_q <= ADDR_W'(BASE_ADDR);
        end else if (pop) begin
            addr_q <= addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_illegal <= 1'b0;
        end else if (accept && illegal) begin
            err_illegal <= 1'b1;
        end
    end

`ifdef ENC_FIELD_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_field <= 1'b0;
        end else if (push && (bus.fmt == FMT_R) && (bus.shamt != 5'd0)
                     && !is_shift_func(bus.func)) begin
            err_field <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench: default encoder plus a narrow-address instance for wrap/clear.
module tb_instr_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr1 = 1'b0;
    logic       clr2 = 1'b0;
    logic [2:0] cnt1;
    logic [2:0] cnt2;
    logic       ill1;
    logic       ill2;
`ifdef ENC_FIELD_CHECK_EN
    logic       ef1;
    logic       ef2;
`endif
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(10)) b1 ();
    instr_encoder_if #(.ADDR_W(2))  b2 ();

    instr_encoder #(.DEPTH(4), .ADDR_W(10), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .bus(b1), .addr_clr(clr1), .count(cnt1),
`ifdef ENC_FIELD_CHECK_EN
        .err_field(ef1),
`endif
        .err_illegal(ill1)
    );

    instr_encoder #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(1)) dut2 (
        .clk(clk), .rst(rst), .bus(b2), .addr_clr(clr2), .count(cnt2),
`ifdef ENC_FIELD_CHECK_EN
        .err_field(ef2),
`endif
        .err_illegal(ill2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_r(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
        b1.fmt = 2'd0; b1.opcode = 6'd0; b1.rs = rs; b1.rt = rt; b1.rd = rd;
        b1.shamt = sh; b1.func = fn; b1.imm = 16'hFFFF; b1.index = 26'h3FFFFFF;
    endtask

    task automatic drive_j1(input logic [25:0] idx);
        b1.fmt = 2'd2; b1.opcode = 6'h02; b1.index = idx;
        b1.rs = 5'h1F; b1.rt = 5'h1F; b1.rd = 5'h1F; b1.shamt = 5'h1F; b1.func = 6'h3F; b1.imm = 16'hFFFF;
    endtask

    task automatic apply_reset();
        b1.in_valid = 1'b0;
        b2.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        b1.in_valid = 0; b1.wr_ready = 0; b2.in_valid = 0; b2.wr_ready = 0;
        drive_r(0, 0, 0, 0, 0);
        b2.fmt = 2'd2; b2.opcode = 6'h02; b2.rs = 0; b2.rt = 0; b2.rd = 0;
        b2.shamt = 0; b2.func = 0; b2.imm = 0; b2.index = 0;
        tick();
        n_chk++; if (cnt1 !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", cnt1); end
        n_chk++; if (b1.wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got %b exp 0", b1.wr_en); end
        n_chk++; if (b1.wr_addr !== 10'd0) begin n_fail++; $display("FAIL reset_wr_addr got %0d exp 0", b1.wr_addr); end
        n_chk++; if (ill1 !== 1'b0) begin n_fail++; $display("FAIL reset_err_illegal got %b exp 0", ill1); end
        n_chk++; if (b1.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", b1.in_ready); end
        n_chk++; if (b2.wr_addr !== 2'd1) begin n_fail++; $display("FAIL reset_base_addr got %0d exp 1", b2.wr_addr); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_r_encode();
        b1.wr_ready = 1;
        drive_r(1, 2, 3, 0, 6'h20);
        b1.in_valid = 1;
        tick();
        n_chk++; if (b1.wr_en !== 1'b1) begin n_fail++; $display("FAIL r_wr_en got %b exp 1", b1.wr_en); end
        n_chk++; if (b1.wr_data !== 32'h00221820) begin n_fail++; $display("FAIL r_data got %h exp 00221820", b1.wr_data); end
        n_chk++; if (b1.wr_addr !== 10'd0) begin n_fail++; $display("FAIL r_addr got %0d exp 0", b1.wr_addr); end
        drive_r(1, 2, 4, 0, 6'h20);
        tick();
        b1.in_valid = 0;
        n_chk++; if (b1.wr_data !== 32'h00222020) begin n_fail++; $display("FAIL r2_data got %h exp 00222020", b1.wr_data); end
        n_chk++; if (b1.wr_addr !== 10'd1) begin n_fail++; $display("FAIL r2_addr got %0d exp 1", b1.wr_addr); end
        n_chk++; if (cnt1 !== 3'd1) begin n_fail++; $display("FAIL pushpop_count got %0d exp 1", cnt1); end
        tick();
        n_chk++; if (cnt1 !== 3'd0 || b1.wr_en !== 1'b0) begin n_fail++; $display("FAIL r_drain count %0d wr_en %b exp 0 0", cnt1, b1.wr_en); end
        n_chk++; if (b1.wr_addr !== 10'd2) begin n_fail++; $display("FAIL r_next_addr got %0d exp 2", b1.wr_addr); end
    endtask

    task automatic test_ij_encode();
        b1.wr_ready = 0;
        b1.fmt = 2'd1; b1.opcode = 6'h23; b1.rs = 5'd29; b1.rt = 5'd8; b1.imm = 16'h0004;
        b1.rd = 5'h1F; b1.shamt = 5'h1F; b1.func = 6'h3F; b1.index = 26'h3FFFFFF;
        b1.in_valid = 1;
        tick();
        drive_j1(26'h0100000);
        tick();
        b1.in_valid = 0;
        b1.wr_ready = 1;
        n_chk++; if (b1.wr_data !== 32'h8FA80004) begin n_fail++; $display("FAIL i_data got %h exp 8fa80004", b1.wr_data); end
        n_chk++; if (b1.wr_addr !== 10'd2) begin n_fail++; $display("FAIL i_addr got %0d exp 2", b1.wr_addr); end
        tick();
        n_chk++; if (b1.wr_data !== 32'h08100000) begin n_fail++; $display("FAIL j_data got %h exp 08100000", b1.wr_data); end
        n_chk++; if (b1.wr_addr !== 10'd3) begin n_fail++; $display("FAIL j_addr got %0d exp 3", b1.wr_addr); end
        tick();
    endtask

    task automatic test_backpressure();
        apply_reset();
        b1.wr_ready = 0;
        b1.in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            drive_j1(26'(i));
            tick();
            n_chk++; if (cnt1 !== 3'(i + 1)) begin n_fail++; $display("FAIL bp_count[%0d] got %0d exp %0d", i, cnt1, i + 1); end
            n_chk++; if (b1.in_ready !== (i < 3)) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b exp %b", i, b1.in_ready, i < 3); end
        end
        drive_j1(26'd4);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_chk++; if (cnt1 !== 3'd4 || b1.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold count %0d in_ready %b exp 4 0", cnt1, b1.in_ready); end
            n_chk++; if (b1.wr_data !== 32'h08000000 || b1.wr_addr !== 10'd0) begin n_fail++; $display("FAIL bp_stable data %h addr %0d exp 08000000 0", b1.wr_data, b1.wr_addr); end
        end
        b1.wr_ready = 1;
        for (int j = 0; j < 4; j++) begin
            n_chk++; if (b1.wr_en !== 1'b1 || b1.wr_data !== (32'h08000000 | 32'(j)) || b1.wr_addr !== 10'(j)) begin
                n_fail++; $display("FAIL bp_drain[%0d] wr_en %b data %h addr %0d exp 1 %h %0d", j, b1.wr_en, b1.wr_data, b1.wr_addr, 32'h08000000 | 32'(j), j);
            end
            tick();
            if (j == 1) b1.in_valid = 0;
        end
        n_chk++; if (b1.wr_data !== 32'h08000004 || b1.wr_addr !== 10'd4 || cnt1 !== 3'd1) begin
            n_fail++; $display("FAIL bp_fifth data %h addr %0d count %0d exp 08000004 4 1", b1.wr_data, b1.wr_addr, cnt1);
        end
        tick();
        n_chk++; if (cnt1 !== 3'd0) begin n_fail++; $display("FAIL bp_empty got %0d exp 0", cnt1); end
    endtask

    task automatic test_illegal();
        b1.wr_ready = 1;
        drive_j1(26'h0000055);
        b1.fmt = 2'd3;
        b1.in_valid = 1;
        #1;
        n_chk++; if (b1.in_ready !== 1'b1) begin n_fail++; $display("FAIL ill_in_ready got %b exp 1", b1.in_ready); end
        tick();
        b1.in_valid = 0;
        n_chk++; if (cnt1 !== 3'd0 || b1.wr_en !== 1'b0) begin n_fail++; $display("FAIL ill_no_push count %0d wr_en %b exp 0 0", cnt1, b1.wr_en); end
        n_chk++; if (ill1 !== 1'b1) begin n_fail++; $display("FAIL ill_flag got %b exp 1", ill1); end
        drive_j1(26'h0000077);
        b1.in_valid = 1;
        tick();
        b1.in_valid = 0;
        n_chk++; if (b1.wr_data !== 32'h08000077 || b1.wr_addr !== 10'd5) begin n_fail++; $display("FAIL ill_next data %h addr %0d exp 08000077 5", b1.wr_data, b1.wr_addr); end
        tick();
        tick();
        n_chk++; if (ill1 !== 1'b1) begin n_fail++; $display("FAIL ill_sticky got %b exp 1", ill1); end
    endtask

    task automatic test_reset_mid();
        b1.wr_ready = 0;
        b1.in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            drive_j1(26'(i + 8));
            tick();
        end
        b1.in_valid = 0;
        n_chk++; if (cnt1 !== 3'd3 || b1.wr_en !== 1'b1) begin n_fail++; $display("FAIL mid_pre count %0d wr_en %b exp 3 1", cnt1, b1.wr_en); end
        #2 rst = 1'b1;
        #1;
        n_chk++; if (b1.wr_en !== 1'b0 || cnt1 !== 3'd0) begin n_fail++; $display("FAIL mid_rst wr_en %b count %0d exp 0 0", b1.wr_en, cnt1); end
        n_chk++; if (b1.wr_addr !== 10'd0 || ill1 !== 1'b0) begin n_fail++; $display("FAIL mid_rst addr %0d err %b exp 0 0", b1.wr_addr, ill1); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_wrap_clear();
        logic [1:0] exp_addr [5];
        exp_addr[0] = 2'd1; exp_addr[1] = 2'd2; exp_addr[2] = 2'd3; exp_addr[3] = 2'd0; exp_addr[4] = 2'd1;
        b2.wr_ready = 1;
        b2.in_valid = 1;
        for (int k = 0; k < 5; k++) begin
            b2.index = 26'(k);
            tick();
            n_chk++; if (b2.wr_addr !== exp_addr[k] || b2.wr_data !== (32'h08000000 | 32'(k))) begin
                n_fail++; $display("FAIL wrap[%0d] addr %0d data %h exp %0d %h", k, b2.wr_addr, b2.wr_data, exp_addr[k], 32'h08000000 | 32'(k));
            end
        end
        b2.index = 26'd5;
        tick();
        n_chk++; if (b2.wr_addr !== 2'd2) begin n_fail++; $display("FAIL clr_pre addr %0d exp 2", b2.wr_addr); end
        b2.index = 26'd6;
        clr2 = 1;
        tick();
        clr2 = 0;
        b2.in_valid = 0;
        n_chk++; if (b2.wr_addr !== 2'd1 || b2.wr_data !== 32'h08000006) begin n_fail++; $display("FAIL clr_post addr %0d data %h exp 1 08000006", b2.wr_addr, b2.wr_data); end
        tick();
        n_chk++; if (cnt2 !== 3'd0 || b2.wr_addr !== 2'd2) begin n_fail++; $display("FAIL clr_drain count %0d addr %0d exp 0 2", cnt2, b2.wr_addr); end
    endtask

    initial begin
        test_reset();
        test_r_encode();
        test_ij_encode();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_wrap_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Inverse of the instruction field splitter. Accepts MIPS instruction fields plus a format tag over a valid/ready handshake and packs them into 32-bit R/I/J words. Buffers the words in a small FIFO and drains them, one per accepted beat, into the instruction-memory write port at an auto-incrementing word address. Sits between the test/boot program source and the instruction memory; used to load programs at reset time.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16
ADDR_W, 10, instruction-memory word-address width
BASE_ADDR, 0, address of the first word written after reset or addr_clr

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  field tuple present
in_ready  out  1  encoder can accept a tuple
fmt  in  2  0=R, 1=I, 2=J, 3=illegal
opcode  in  6  bits [31:26]
rs  in  5  bits [25:21] (R, I)
rt  in  5  bits [20:16] (R, I)
rd  in  5  bits [15:11] (R)
shamt  in  5  bits [10:6] (R)
func  in  6  bits [5:0] (R)
imm  in  16  bits [15:0] (I)
index  in  26  bits [25:0] (J)
addr_clr  in  1  synchronous reload of the address counter to BASE_ADDR
wr_en  out  1  memory write request
wr_ready  in  1  memory accepts the write this cycle
wr_addr  out  ADDR_W  word address of the write
wr_data  out  32  encoded instruction
count  out  clog2(DEPTH)+1  FIFO occupancy
err_illegal  out  1  sticky illegal-format flag

Behaviour:
- Reset (async): FIFO pointers=0; count=0; wr_en=0; wr_addr=BASE_ADDR; err_illegal=0; in_ready=1. Clearing happens immediately, mid-transfer included; any buffered words are discarded.
- Encoding (combinational on the inputs):
  - R = {opcode, rs, rt, rd, shamt, func}
  - I = {opcode, rs, rt, imm}
  - J = {opcode, index}
  - Unused fields are ignored.
- Push: occurs when in_valid && in_ready. in_ready = (count != DEPTH) and depends only on registered state.
- fmt=3: the tuple is accepted (handshake completes) but not pushed; err_illegal is set and stays high until rst.
- Drain: wr_en = (count != 0); wr_data = FIFO head; wr_addr = address register. A pop occurs when wr_en && wr_ready. wr_data and wr_addr must hold stable while wr_en=1 and wr_ready=0.
- Latency: a tuple accepted at edge N presents wr_en=1 from edge N (visible in cycle N+1) if the FIFO was empty. Throughput is 1 word/cycle.
- Simultaneous push and pop: count is unchanged. A full FIFO with a pop does not accept a push that cycle, because in_ready was low. An empty FIFO cannot pop.
- Address counter: +1 per pop, modulo 2^ADDR_W; wraps silently from all-ones to 0.
- addr_clr: takes priority over increment. If it coincides with a pop, the pop writes the current address and the counter loads BASE_ADDR.
- count = pushes − pops since reset; never exceeds DEPTH.

Optional Feature:
ENC_FIELD_CHECK_EN
- Defined: additional legality checks.
  - fmt=R with opcode≠0, or fmt=I/J with opcode=0, is also treated as illegal: accepted, not pushed, err_illegal set.
  - A second sticky output, err_field (1 bit, reset 0), is set by any R tuple with shamt≠0 and func∉{0x00,0x02,0x03}; that word is still pushed.
- Undefined: only fmt=3 is illegal, and err_field is absent.

Decomposition:
- Package instr_pkg:
  - FMT_R/FMT_I/FMT_J/FMT_BAD 2-bit constants
  - field bit-position constants (OP_HI=31, RS_HI=25, RT_HI=20, RD_HI=15, SH_HI=10, FN_HI=5)
  - the legal shift func codes
  - it is shared with the field splitter.
- Sub-module sync_fifo: WIDTH=32, DEPTH; push/pop/full/empty/count; async active-high reset. The encode mux and address counter stay in the top module.

Test Plan:
- R encode: fmt=0, op=0, rs=1, rt=2, rd=3, shamt=0, func=0x20, wr_ready=1 → wr_data=0x00221820, wr_addr=0, next word at wr_addr=1.
- I/J encode: fmt=1, op=0x23, rs=29, rt=8, imm=0x0004 → wr_data=0x8FA80004; fmt=2, op=0x02, index=0x0100000 → wr_data=0x08100000.
- Backpressure: wr_ready=0, push 5 tuples with DEPTH=4 → in_ready=0 after the 4th, count=4, wr_data/wr_addr stable. Release wr_ready → 4 writes at addresses 0..3 in order, then the 5th tuple is accepted.
- Illegal: fmt=3 with in_valid=1 → in_ready stays 1, count unchanged, no wr_en, err_illegal=1 until rst.
- Wrap/clear: ADDR_W=2, 5 writes → addresses 0,1,2,3,0. addr_clr coinciding with a pop at addr 2 → that write at 2, next write at BASE_ADDR.
- Reset mid-operation: rst asserted with count=3 and wr_en=1 → same cycle wr_en=0, count=0, wr_addr=BASE_ADDR, err_illegal=0.
